connect4_move_engine: RTL

- Datapath stage feeding the Connect-4 game-control FSM.
- Holds the 6x7 board. Accepts a column drop request from the current player, finds the lowest free cell, and writes the piece.
- Then checks for four-in-a-row through the placed cell.
- Reports per move: move-valid, winner and draw flags. These drive the controller's verify/winner decisions and the display board.

---
 rtl/connect4_move_engine.sv | 116 +++++++++++
 1 files changed

// File: rtl/connect4_move_engine.sv
// connect4_move_engine: 6x7 board holder that drops a piece into a column and checks four-in-a-row through it.
module connect4_move_engine #(
  parameter int ROWS    = 6,
  parameter int COLS    = 7,
  parameter int WIN_LEN = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   mov_req,
  input  logic [2:0]             columna,
  input  logic                   jugador,
  output logic                   busy,
  output logic                   done,
  output logic                   valido,
  output logic                   ganador,
  output logic                   empate,
  output logic [2*ROWS*COLS-1:0] board,
  output logic [5:0]             mov_count
);
  typedef enum logic [2:0] {IDLE, CHK_COL, DROP, WRITE, CHECK, REPORT} state_t;
  state_t                 state_q;
  logic [2:0]             col_q, row_q;
  logic [1:0]             dir_q;
  logic                   jug_q, win_q, acc_q, done_q, valido_q, ganador_q, empate_q;
  logic [2*ROWS*COLS-1:0] board_q;
  logic [5:0]             cnt_q;
  logic [1:0]             piece;
  logic                   hit_d, go_f, go_b;
  int                     run, dr, dc;
  // Off-board coordinates read as empty, so walks stop at the edge for free.
  function automatic logic [1:0] cell_at(input logic [2*ROWS*COLS-1:0] b, input int r, input int c);
    cell_at = 2'b00;
    for (int i = 0; i < ROWS; i++)
      for (int j = 0; j < COLS; j++)
        if (i == r && j == c) cell_at = b[2*(i*COLS+j) +: 2];
  endfunction
  assign piece = jug_q ? 2'b10 : 2'b01;
  always_comb begin
    dr   = (dir_q == 2'd0) ? 0 : 1;
    dc   = (dir_q == 2'd1) ? 0 : (dir_q == 2'd3) ? -1 : 1;
    run  = 1;
    go_f = 1'b1;
    go_b = 1'b1;
    for (int k = 1; k < WIN_LEN; k++) begin
      go_f = go_f && (cell_at(board_q, int'(row_q) + k*dr, int'(col_q) + k*dc) == piece);
      go_b = go_b && (cell_at(board_q, int'(row_q) - k*dr, int'(col_q) - k*dc) == piece);
      run  = run + int'(go_f) + int'(go_b);
    end
    hit_d = run >= WIN_LEN;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE; col_q <= '0; row_q <= '0; dir_q <= '0; jug_q <= 1'b0;
      win_q <= 1'b0; acc_q <= 1'b0; done_q <= 1'b0; valido_q <= 1'b0;
      ganador_q <= 1'b0; empate_q <= 1'b0; board_q <= '0; cnt_q <= '0;
    end else if (clear) begin
      state_q <= IDLE; col_q <= '0; row_q <= '0; dir_q <= '0; jug_q <= 1'b0;
      win_q <= 1'b0; acc_q <= 1'b0; done_q <= 1'b0; valido_q <= 1'b0;
      ganador_q <= 1'b0; empate_q <= 1'b0; board_q <= '0; cnt_q <= '0;
    end else begin
      done_q    <= 1'b0;
      valido_q  <= 1'b0;
      ganador_q <= 1'b0;
      empate_q  <= 1'b0;
      case (state_q)
        IDLE: if (mov_req) begin
          col_q   <= columna;
          jug_q   <= jugador;
          state_q <= CHK_COL;
        end
        CHK_COL: if (int'(col_q) >= COLS || cell_at(board_q, ROWS-1, int'(col_q)) != 2'b00) begin
          acc_q   <= 1'b0;
          win_q   <= 1'b0;
          done_q  <= 1'b1;
          state_q <= REPORT;
        end else begin
          acc_q   <= 1'b1;
          row_q   <= '0;
          state_q <= DROP;
        end
        DROP: if (cell_at(board_q, int'(row_q), int'(col_q)) == 2'b00) state_q <= WRITE;
              else row_q <= row_q + 3'd1;
        WRITE: begin
          for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++)
              if (i == int'(row_q) && j == int'(col_q)) board_q[2*(i*COLS+j) +: 2] <= piece;
          cnt_q   <= cnt_q + 6'd1;
          dir_q   <= '0;
          win_q   <= 1'b0;
          state_q <= CHECK;
        end
        CHECK: begin
          win_q <= win_q | hit_d;
          dir_q <= dir_q + 2'd1;
          if (dir_q == 2'd3) begin
            done_q    <= 1'b1;
            valido_q  <= acc_q;
            ganador_q <= win_q | hit_d;
            empate_q  <= acc_q && !(win_q | hit_d) && cnt_q == 6'(ROWS*COLS);
            state_q   <= REPORT;
          end
        end
        REPORT: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign busy      = state_q != IDLE;
  assign done      = done_q;
  assign valido    = valido_q;
  assign ganador   = ganador_q;
  assign empate    = empate_q;
  assign board     = board_q;
  assign mov_count = cnt_q;
endmodule
